// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction loader and the main decoder:
// supported opcodes, loader FSM encoding and small helper functions.
package imem_loader_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN0  = 3'd1,
        LEN1  = 3'd2,
        DATA  = 3'd3,
        WRITE = 3'd4,
        CHK   = 3'd5,
        DONE  = 3'd6,
        ERR   = 3'd7
    } ld_state_e;

    function automatic logic op_supported(input logic [6:0] op);
        logic ok_s;
        case (op)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_BRANCH: ok_s = 1'b1;
            default:                                ok_s = 1'b0;
        endcase
        return ok_s;
    endfunction

    function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/imem_loader_byte_to_word.sv
// Little-endian 4-byte assembler: each accepted byte lands in the lane given by
// a 2-bit index; a one-cycle pulse follows the byte that completes a word.
module imem_loader_byte_to_word
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              byte_en,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] word,
    output logic [1:0]        lane,
    output logic              word_done
);

    logic [WORD_W-1:0] word_r;
    logic [1:0]        lane_r;
    logic              done_r;

    // Lane placement, lane index advance and completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_r <= {WORD_W{1'b0}};
            lane_r <= 2'd0;
            done_r <= 1'b0;
        end else if (clr) begin
            word_r <= {WORD_W{1'b0}};
            lane_r <= 2'd0;
            done_r <= 1'b0;
        end else begin
            done_r <= byte_en && (lane_r == 2'd3);
            if (byte_en) begin
                word_r[{lane_r, 3'b000} +: 8] <= byte_in;
                lane_r                       <= lane_r + 2'd1;
            end else begin
                lane_r <= lane_r;
            end
        end
    end

    assign word      = word_r;
    assign lane      = lane_r;
    assign word_done = done_r;

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: parses a length/words/checksum byte
// stream, writes each word to imem and releases the core only after a clean load.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   bad_op_cnt
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_MAX  = {(ADDR_W+1){1'b1}};

    ld_state_e         state_r;
    ld_state_e         state_nxt_s;
    logic              ready_nxt_s;
    logic              start_ok_s;
    logic              xfer_s;
    logic [15:0]       len_s;
    logic [7:0]        len_lo_r;
    logic [ADDR_W:0]   len_r;
    logic [ADDR_W:0]   wcnt_r;
    logic [ADDR_W-1:0] addr_r;
    logic [7:0]        chk_r;
    logic [ADDR_W:0]   bad_op_cnt_r;
    logic              byte_ready_r;
    logic              core_hold_r;
    logic              done_r;
    logic              err_r;
    logic [31:0]       asm_word_s;
    logic [1:0]        asm_lane_s;
    logic              asm_done_s;

    assign xfer_s     = byte_valid & byte_ready_r;
    assign len_s      = {byte_data, len_lo_r};
    assign start_ok_s = start && ((state_r == IDLE) || (state_r == DONE) || (state_r == ERR));

    // The assembler register doubles as the write-data register; its pulse is the WRITE cycle.
    imem_loader_byte_to_word u_b2w (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (start_ok_s),
        .byte_en   (xfer_s && (state_r == DATA)),
        .byte_in   (byte_data),
        .word      (asm_word_s),
        .lane      (asm_lane_s),
        .word_done (asm_done_s)
    );

    // Next-state decode plus the ready flag for the coming state.
    always_comb begin
        state_nxt_s = state_r;
        ready_nxt_s = 1'b0;
        case (state_r)
            IDLE, DONE, ERR: begin
                if (start) state_nxt_s = LEN0;
                else       state_nxt_s = state_r;
            end
            LEN0: begin
                if (xfer_s) state_nxt_s = LEN1;
                else        state_nxt_s = LEN0;
            end
            LEN1: begin
                if (!xfer_s)                  state_nxt_s = LEN1;
                else if (len_s > 16'(DEPTH))  state_nxt_s = ERR;
                else if (len_s == 16'd0)      state_nxt_s = CHK;
                else                          state_nxt_s = DATA;
            end
            DATA: begin
                if (xfer_s && (asm_lane_s == 2'd3)) state_nxt_s = WRITE;
                else                                state_nxt_s = DATA;
            end
            WRITE: begin
                if ((wcnt_r + CNT_ONE) == len_r) state_nxt_s = CHK;
                else                             state_nxt_s = DATA;
            end
            CHK: begin
                if (!xfer_s)                 state_nxt_s = CHK;
                else if (byte_data == chk_r) state_nxt_s = DONE;
                else                         state_nxt_s = ERR;
            end
            default: state_nxt_s = IDLE;
        endcase
        case (state_nxt_s)
            LEN0, LEN1, DATA, CHK: ready_nxt_s = 1'b1;
            default:               ready_nxt_s = 1'b0;
        endcase
    end

    // State register and status flags registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            byte_ready_r <= 1'b0;
            core_hold_r  <= 1'b1;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            byte_ready_r <= ready_nxt_s;
            core_hold_r  <= (state_nxt_s != DONE);
            done_r       <= (state_nxt_s == DONE);
            err_r        <= (state_nxt_s == ERR);
        end
    end

    // Length capture, address/word counters, checksum and unsupported-opcode count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_lo_r     <= 8'd0;
            len_r        <= {(ADDR_W+1){1'b0}};
            wcnt_r       <= {(ADDR_W+1){1'b0}};
            addr_r       <= {ADDR_W{1'b0}};
            chk_r        <= 8'd0;
            bad_op_cnt_r <= {(ADDR_W+1){1'b0}};
        end else if (start_ok_s) begin
            wcnt_r       <= {(ADDR_W+1){1'b0}};
            addr_r       <= {ADDR_W{1'b0}};
            chk_r        <= 8'd0;
            bad_op_cnt_r <= {(ADDR_W+1){1'b0}};
        end else begin
            if ((state_r == LEN0) && xfer_s) len_lo_r <= byte_data;
            if ((state_r == LEN1) && xfer_s) len_r    <= len_s[ADDR_W:0];
            if ((state_r == DATA) && xfer_s) chk_r    <= chk_update(chk_r, byte_data);
            if (state_r == WRITE) begin
                addr_r <= addr_r + ADDR_ONE;
                wcnt_r <= wcnt_r + CNT_ONE;
                if (!op_supported(asm_word_s[6:0]) && (bad_op_cnt_r != CNT_MAX)) begin
                    bad_op_cnt_r <= bad_op_cnt_r + CNT_ONE;
                end
            end
        end
    end

    assign byte_ready = byte_ready_r;
    assign imem_we    = asm_done_s;
    assign imem_addr  = addr_r;
    assign imem_wdata = asm_word_s;
    assign core_hold  = core_hold_r;
    assign done       = done_r;
    assign err        = err_r;
    assign bad_op_cnt = bad_op_cnt_r;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of load streams with expected results,
// plus gap, mid-load reset and stray-start sequences.
module tb_imem_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    typedef struct {
        logic [15:0]      n;
        logic [3:0][31:0] w;
        logic [7:0]       chk;
        logic             exp_done;
        logic             exp_err;
        logic [ADDR_W:0]  exp_bad;
        int               exp_wr;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = 8'd0;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_hold;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   bad_op_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_n = 0;
    logic inv_on = 1'b0;
    logic [ADDR_W-1:0] wr_addr [64];
    logic [31:0]       wr_data [64];
    logic [7:0]        sbytes [64];
    int                sn;
    vec_t              vecs [7];

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_hold  (core_hold),
        .done       (done),
        .err        (err),
        .bad_op_cnt (bad_op_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every write strobe seen at the falling edge.
    always @(negedge clk) begin
        if (imem_we) begin
            if (wr_n < 64) begin
                wr_addr[wr_n] <= imem_addr;
                wr_data[wr_n] <= imem_wdata;
            end
            wr_n <= wr_n + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Output invariants checked every cycle once the bench is running.
    always @(negedge clk) begin
        if (rst_n && inv_on) begin
            check("ready_outside_io_states", {31'd0, byte_ready & (imem_we | done | err)}, 32'd0);
            check("hold_vs_done", {31'd0, core_hold}, {31'd0, !done});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic set_vec(input int i, input logic [15:0] n, input logic [31:0] w0,
                           input logic [31:0] w1, input logic [31:0] w2, input logic [31:0] w3,
                           input logic [7:0] chk, input logic d, input logic e,
                           input logic [ADDR_W:0] bad, input int wr);
        vecs[i].n = n;
        vecs[i].w[0] = w0; vecs[i].w[1] = w1; vecs[i].w[2] = w2; vecs[i].w[3] = w3;
        vecs[i].chk = chk;
        vecs[i].exp_done = d; vecs[i].exp_err = e;
        vecs[i].exp_bad = bad; vecs[i].exp_wr = wr;
    endtask

    task automatic build(input vec_t v);
        sbytes[0] = v.n[7:0];
        sbytes[1] = v.n[15:8];
        sn = 2;
        if (int'(v.n) <= DEPTH) begin
            for (int w = 0; w < int'(v.n); w++) begin
                for (int k = 0; k < 4; k++) begin
                    sbytes[sn] = v.w[w][8*k +: 8];
                    sn++;
                end
            end
            sbytes[sn] = v.chk;
            sn++;
        end
    endtask

    task automatic pulse_start(output int c0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        c0 = cyc;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit sent;
        sent = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            byte_valid = 1'b0;
        end
        for (int t = 0; t < 40 && !sent; t++) begin
            @(negedge clk);
            byte_valid = 1'b1;
            byte_data  = b;
            if (byte_ready) begin
                @(posedge clk);
                #1;
                byte_valid = 1'b0;
                sent = 1'b1;
            end
        end
        if (!sent) begin
            byte_valid = 1'b0;
            checks++;
            errors++;
            $display("FAIL send_byte: byte 0x%0h not accepted within 40 cycles, expected acceptance", b);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".byte_ready"}, {31'd0, byte_ready}, 32'd0);
        check({tag, ".imem_we"},    {31'd0, imem_we},    32'd0);
        check({tag, ".imem_addr"},  32'(imem_addr),      32'd0);
        check({tag, ".imem_wdata"}, imem_wdata,          32'd0);
        check({tag, ".core_hold"},  {31'd0, core_hold},  32'd1);
        check({tag, ".done"},       {31'd0, done},       32'd0);
        check({tag, ".err"},        {31'd0, err},        32'd0);
        check({tag, ".bad_op_cnt"}, 32'(bad_op_cnt),     32'd0);
    endtask

    task automatic check_result(input vec_t v, input int base, input string tag);
        check({tag, ".done"},       {31'd0, done},       {31'd0, v.exp_done});
        check({tag, ".err"},        {31'd0, err},        {31'd0, v.exp_err});
        check({tag, ".core_hold"},  {31'd0, core_hold},  {31'd0, !v.exp_done});
        check({tag, ".byte_ready"}, {31'd0, byte_ready}, 32'd0);
        check({tag, ".bad_op_cnt"}, 32'(bad_op_cnt),     32'(v.exp_bad));
        check({tag, ".write_count"}, wr_n - base,        v.exp_wr);
        for (int i = 0; i < v.exp_wr; i++) begin
            if (base + i < 64) begin
                check($sformatf("%s.wr%0d_addr", tag, i), 32'(wr_addr[base+i]), i);
                check($sformatf("%s.wr%0d_data", tag, i), wr_data[base+i], v.w[i]);
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input int max_gap, input string tag);
        int base;
        int c0;
        int exp_cyc;
        build(v);
        base = wr_n;
        pulse_start(c0);
        for (int i = 0; i < sn; i++) begin
            send_byte(sbytes[i], (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)));
        end
        exp_cyc = (int'(v.n) > DEPTH) ? 2 : 3 + 5 * int'(v.n);
        if (max_gap == 0) check({tag, ".latency"}, cyc - c0, exp_cyc);
        repeat (2) @(negedge clk);
        #1;
        check_result(v, base, tag);
    endtask

    initial begin
        int base;
        int c0;
        //       idx n        w0            w1            w2            w3            chk    done  err   bad   wr
        set_vec(0, 16'd2,   32'h00A00093, 32'h002081B3, 32'h0,       32'h0,       8'h21, 1'b1, 1'b0, 9'd1, 2);
        set_vec(1, 16'd0,   32'h0,        32'h0,        32'h0,       32'h0,       8'h00, 1'b1, 1'b0, 9'd0, 0);
        set_vec(2, 16'd0,   32'h0,        32'h0,        32'h0,       32'h0,       8'h01, 1'b0, 1'b1, 9'd0, 0);
        set_vec(3, 16'd257, 32'h0,        32'h0,        32'h0,       32'h0,       8'h00, 1'b0, 1'b1, 9'd0, 0);
        set_vec(4, 16'd4,   32'h00002003, 32'h00112023, 32'h00208463, 32'h0000006F, 8'h99, 1'b1, 1'b0, 9'd1, 4);
        set_vec(5, 16'd2,   32'h00A00093, 32'h002081B3, 32'h0,       32'h0,       8'h22, 1'b0, 1'b1, 9'd1, 2);
        set_vec(6, 16'd1,   32'h00000033, 32'h0,        32'h0,       32'h0,       8'h33, 1'b1, 1'b0, 9'd0, 1);

        repeat (3) @(negedge clk);
        check_reset_vals("in_reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_vals("after_reset");
        inv_on = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], 0, $sformatf("vec%0d", i));

        run_vec(vecs[4], 3, "gaps");

        // Asynchronous reset after two bytes of the second word.
        build(vecs[0]);
        pulse_start(c0);
        for (int i = 0; i < 8; i++) send_byte(sbytes[i], 0);
        check("pre_rst.imem_addr", 32'(imem_addr), 32'd1);
        check("pre_rst.bad_op_cnt", 32'(bad_op_cnt), 32'd1);
        check("pre_rst.byte_ready", {31'd0, byte_ready}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("rst_release");
        run_vec(vecs[0], 0, "reload");

        // Start pulse while in DATA must be ignored.
        build(vecs[0]);
        base = wr_n;
        pulse_start(c0);
        for (int i = 0; i < 5; i++) send_byte(sbytes[i], 0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 5; i < sn; i++) send_byte(sbytes[i], 0);
        repeat (2) @(negedge clk);
        #1;
        check_result(vecs[0], base, "start_in_data");

        inv_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
